vend_ctrl_multi: RTL and testbench

//  Parametrised vending controller: N_PROD products with per-product prices, N_COIN coin denominations,

---
 rtl/vend_pkg.sv | 12 +
 rtl/change_picker.sv | 19 +
 rtl/vend_ctrl_multi.sv | 125 ++++++++++++
 tb/tb_vend_ctrl_multi.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM state encoding, width helper and default price/coin tables
package vend_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;
  localparam logic [31:0] DEF_PRICES   = {8'd5, 8'd5, 8'd3, 8'd2};
  localparam logic [23:0] DEF_COIN_VAL = {8'd5, 8'd2, 8'd1};
  function automatic int clog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/change_picker.sv
// change_picker: greedy choice of the largest coin denomination not exceeding the credit
module change_picker
  import vend_pkg::*;
#(
  parameter int N_COIN = 3,
  parameter int CW = 8,
  parameter logic [N_COIN*CW-1:0] COIN_VAL = DEF_COIN_VAL
) (
  input  logic [CW-1:0] credit,
  output logic [clog2(N_COIN)-1:0] idx
);
  localparam int W = clog2(N_COIN);
  // denominations ascend, so the last one that fits is the largest
  always_comb begin
    idx = '0;
    for (int k = 0; k < N_COIN; k++)
      if (COIN_VAL[k*CW +: CW] <= credit) idx = W'(k);
  end
endmodule

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-product vending FSM with credit, refund timeout and handshaked change payout
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int N_PROD = 4,
  parameter int N_COIN = 3,
  parameter int CW = 8,
  parameter logic [N_PROD*CW-1:0] PRICES = DEF_PRICES,
  parameter logic [N_COIN*CW-1:0] COIN_VAL = DEF_COIN_VAL,
  parameter int MAX_CREDIT = 50,
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic coin_valid,
  input  logic [clog2(N_COIN)-1:0] coin_sel,
  input  logic sel_valid,
  input  logic [clog2(N_PROD)-1:0] sel_idx,
  input  logic cancel,
  input  logic chg_ready,
  output logic chg_valid,
  output logic [clog2(N_COIN)-1:0] chg_coin,
  output logic vend_valid,
  output logic [clog2(N_PROD)-1:0] vend_idx,
  output logic coin_reject,
  output logic sel_err,
  output logic [CW-1:0] credit,
  output logic busy
);
  localparam int PW = clog2(N_PROD);
  localparam int KW = clog2(N_COIN);
  localparam logic [CW:0] MAXC = (CW+1)'(MAX_CREDIT);
  if (MAX_CREDIT >= (1 << CW) || COIN_VAL[CW-1:0] != CW'(1)) begin : g_bad_param
    $error("vend_ctrl_multi: MAX_CREDIT must fit in CW bits and COIN_VAL[0] must be 1");
  end
  logic [1:0] state;
  logic sel_pending;
  logic [PW-1:0] sel_reg;
  logic [31:0] tmr;
  logic [CW-1:0] price, cval, oval, rem;
  logic [CW:0] sum;
  logic [KW-1:0] pick;
  logic go_vend, tout, quiet;
  // credit left after this cycle's deduction; feeds the greedy picker so chg_coin is ready when registered
  always_comb begin
    price = PRICES[sel_reg*CW +: CW];
    cval = COIN_VAL[coin_sel*CW +: CW];
    oval = COIN_VAL[chg_coin*CW +: CW];
    sum = {1'b0, credit} + {1'b0, cval};
    rem = state == S_VEND ? credit - price : state == S_CHANGE ? credit - oval : credit;
    quiet = !coin_valid && !sel_valid;
    go_vend = sel_pending && credit >= price;
    tout = TIMEOUT != 0 && state == S_CREDIT && quiet && tmr == TIMEOUT - 1;
  end
  change_picker #(.N_COIN(N_COIN), .CW(CW), .COIN_VAL(COIN_VAL)) u_pick (.credit(rem), .idx(pick));
  assign busy = state == S_VEND || state == S_CHANGE;
  // main controller: coin/selection handling, vend, refund and change handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      credit <= '0;
      sel_pending <= 1'b0;
      sel_reg <= '0;
      tmr <= '0;
      chg_valid <= 1'b0;
      chg_coin <= '0;
      vend_valid <= 1'b0;
      vend_idx <= '0;
      coin_reject <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      vend_valid <= 1'b0;
      coin_reject <= 1'b0;
      sel_err <= 1'b0;
      tmr <= state == S_CREDIT && quiet ? tmr + 1 : '0;
      case (state)
        S_IDLE, S_CREDIT: begin
          if (state == S_CREDIT && (cancel || tout)) begin
            state <= credit == 0 ? S_IDLE : S_CHANGE;
            chg_valid <= credit != 0;
            chg_coin <= pick;
            sel_pending <= 1'b0;
            coin_reject <= coin_valid;
          end else begin
            if (coin_valid) begin
              if (sum > MAXC) coin_reject <= 1'b1;
              else begin
                credit <= sum[CW-1:0];
                state <= S_CREDIT;
              end
            end
            if (go_vend) begin
              state <= S_VEND;
              vend_valid <= 1'b1;
              vend_idx <= sel_reg;
            end else if (sel_valid) begin
              if (int'(sel_idx) >= N_PROD) sel_err <= 1'b1;
              else begin
                sel_pending <= 1'b1;
                sel_reg <= sel_idx;
              end
            end
          end
        end
        S_VEND: begin
          coin_reject <= coin_valid;
          credit <= rem;
          sel_pending <= 1'b0;
          state <= rem == 0 ? S_IDLE : S_CHANGE;
          chg_valid <= rem != 0;
          chg_coin <= pick;
        end
        default: begin
          coin_reject <= coin_valid;
          if (chg_ready) begin
            credit <= rem;
            state <= rem == 0 ? S_IDLE : S_CHANGE;
            chg_valid <= rem != 0;
            chg_coin <= pick;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: directed checks of vending, change, refund, timeout, errors and reset
module tb_vend_ctrl_multi;
  localparam int T = 64;
  logic clk = 0, reset = 1, coin_valid = 0, sel_valid = 0, cancel = 0, chg_ready = 0;
  logic [1:0] coin_sel = 0, sel_idx = 0, chg_coin, vend_idx;
  logic chg_valid, vend_valid, coin_reject, sel_err, busy;
  logic [7:0] credit;
  int n_chk = 0, n_pass = 0, sum_out = 0, n_out = 0;
  int cv [3] = '{1, 2, 5};
  vend_ctrl_multi #(
    .N_PROD(3), .N_COIN(3), .CW(8), .PRICES({8'd3, 8'd5, 8'd2}),
    .COIN_VAL({8'd5, 8'd2, 8'd1}), .MAX_CREDIT(50), .TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .chg_ready(chg_ready),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .vend_valid(vend_valid), .vend_idx(vend_idx),
    .coin_reject(coin_reject), .sel_err(sel_err), .credit(credit), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic coin(input logic [1:0] s);
    coin_valid = 1;
    coin_sel = s;
    tick();
    coin_valid = 0;
  endtask
  task automatic sel(input logic [1:0] s);
    sel_valid = 1;
    sel_idx = s;
    tick();
    sel_valid = 0;
  endtask
  task automatic do_cancel();
    cancel = 1;
    tick();
    cancel = 0;
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    check("reset_flags", {chg_valid, vend_valid, coin_reject, sel_err, busy}, 0);
    check("reset_credit", credit, 0);
    coin(0);
    coin(0);
    check("credit_2", credit, 2);
    sel(0);
    check("no_vend_yet", vend_valid, 0);
    tick();
    check("vend0_flags", {vend_valid, busy}, 2'b11);
    check("vend0_idx", vend_idx, 0);
    tick();
    check("vend0_done", {vend_valid, chg_valid, busy}, 0);
    check("vend0_credit", credit, 0);
    coin(2);
    check("credit_5", credit, 5);
    sel(2);
    tick();
    check("vend2_valid", vend_valid, 1);
    check("vend2_idx", vend_idx, 2);
    tick();
    check("vend2_chg", {chg_valid, chg_coin}, 3'b101);
    check("vend2_rem", credit, 2);
    chg_ready = 1;
    tick();
    chg_ready = 0;
    check("vend2_end", {chg_valid, busy}, 0);
    check("vend2_credit0", credit, 0);
    coin(1);
    do_cancel();
    for (int i = 0; i < 3; i++) begin
      check("hold_chg", {chg_valid, chg_coin}, 3'b101);
      check("hold_credit", credit, 2);
      tick();
    end
    chg_ready = 1;
    tick();
    chg_ready = 0;
    check("refund_done", {credit, busy}, 0);
    for (int i = 0; i < 9; i++) coin(2);
    coin(1);
    coin(0);
    check("credit_48", credit, 48);
    coin(2);
    check("over_reject", coin_reject, 1);
    check("over_credit", credit, 48);
    do_cancel();
    check("refund48_coin", {chg_valid, chg_coin}, 3'b110);
    coin(0);
    check("chg_coin_reject", coin_reject, 1);
    check("chg_credit_kept", credit, 48);
    chg_ready = 1;
    for (int i = 0; i < 20 && chg_valid; i++) begin
      sum_out += cv[chg_coin];
      n_out++;
      tick();
    end
    chg_ready = 0;
    check("payout_sum", sum_out, 48);
    check("payout_coins", n_out, 11);
    check("payout_end", {credit, busy}, 0);
    coin(0);
    repeat (T - 1) tick();
    check("pre_timeout", {chg_valid, busy}, 0);
    tick();
    check("timeout_chg", {chg_valid, chg_coin}, 3'b100);
    check("timeout_credit", credit, 1);
    chg_ready = 1;
    tick();
    chg_ready = 0;
    check("timeout_end", {credit, busy}, 0);
    sel(3);
    check("sel_err_pulse", sel_err, 1);
    tick();
    check("sel_err_clear", sel_err, 0);
    coin(2);
    coin(1);
    do_cancel();
    check("mid_chg", {chg_valid, chg_coin}, 3'b110);
    check("mid_credit", credit, 7);
    reset = 1;
    #1;
    check("async_flags", {chg_valid, vend_valid, coin_reject, sel_err, busy}, 0);
    check("async_credit", {credit, chg_coin, vend_idx}, 0);
    tick();
    reset = 0;
    tick();
    check("post_reset", {credit, busy, chg_valid}, 0);
    coin(0);
    check("post_reset_coin", credit, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
